// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory access stage: one handshaked load/store per instruction
module mem_access_unit #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        we_mem,
  input  logic              l_byte,
  input  logic              alu_reg,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [1:0]        err_code,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  localparam logic [7:0] WAIT_LIM     = 8'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              is_load_q;
  logic              l_byte_q;
  logic [1:0]        lane_q;
  logic [31:0]       rdata_q;
  logic [31:0]       load_value;

  logic accept;
  logic req_store;
  logic req_load;
  logic req_word;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign req_store = (we_mem == 2'b01) || (we_mem == 2'b10);
  assign req_load  = (we_mem == 2'b00) && alu_reg;
  // Word-sized accesses are the only ones that can be misaligned.
  assign req_word  = (we_mem == 2'b01) || (req_load && !l_byte);

  // State register together with the wait counter and the pending error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: classify at acceptance, then wait for ack or timeout in REQ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = 8'd0;
          err_d = ERR_NONE;
          if (we_mem == 2'b11) begin
            state_d = S_RESP;
            err_d   = ERR_ILLEGAL;
          end else if (req_word && (addr[1:0] != 2'b00)) begin
            state_d = S_RESP;
            err_d   = ERR_MISALIGN;
          end else if (req_store || req_load) begin
            state_d = S_REQ;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == WAIT_LIM) begin
            state_d = S_RESP;
            err_d   = ERR_TIMEOUT;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        err_d   = ERR_NONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        err_d   = ERR_NONE;
      end
    endcase
  end

  // Outputs decoded from state; memory fields are only driven while requesting.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_req    = (state_q == S_REQ);
    resp_valid = (state_q == S_RESP);
    resp_err   = resp_valid && (err_q != ERR_NONE);
    err_code   = resp_valid ? err_q : ERR_NONE;
    mem_we     = mem_req && we_q;
    mem_be     = mem_req ? be_q : 4'b0000;
    mem_addr   = mem_req ? addr_q : '0;
    mem_wdata  = mem_req ? wdata_q : 32'd0;
    rdata      = rdata_q;
  end

  // Select and zero-extend the addressed byte lane for LBU.
  always_comb begin
    load_value = mem_rdata;
    if (l_byte_q) begin
      case (lane_q)
        2'd0:    load_value = {24'd0, mem_rdata[7:0]};
        2'd1:    load_value = {24'd0, mem_rdata[15:8]};
        2'd2:    load_value = {24'd0, mem_rdata[23:16]};
        default: load_value = {24'd0, mem_rdata[31:24]};
      endcase
    end
  end

  // Capture the request operands at acceptance and the load result on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      is_load_q <= 1'b0;
      l_byte_q  <= 1'b0;
      lane_q    <= 2'd0;
      rdata_q   <= 32'd0;
    end else begin
      if (accept) begin
        addr_q    <= {addr[ADDR_W-1:2], 2'b00};
        we_q      <= req_store;
        be_q      <= (we_mem == 2'b10) ? (4'b0001 << addr[1:0]) : 4'b1111;
        wdata_q   <= (we_mem == 2'b10) ? {4{wdata[7:0]}} :
                     (we_mem == 2'b01) ? wdata : 32'd0;
        is_load_q <= req_load;
        l_byte_q  <= l_byte;
        lane_q    <= addr[1:0];
      end
      if ((state_q == S_REQ) && mem_ack && is_load_q) begin
        rdata_q <= load_value;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int ADDR_W   = 32;
  localparam int WAIT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        we_mem;
  logic              l_byte;
  logic              alu_reg;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [1:0]        err_code;
  logic [31:0]       rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] ref_rdata = 32'd0;

  mem_access_unit #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .we_mem(we_mem), .l_byte(l_byte), .alu_reg(alu_reg),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .err_code(err_code),
    .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    we_mem  = 2'($urandom);
    l_byte  = 1'($urandom);
    alu_reg = 1'($urandom);
    addr    = $urandom;
    wdata   = $urandom;
  endtask

  // One instruction: drive it, play the memory (ack on the ack_at-th request cycle), check against the model.
  task automatic run_txn(input logic [1:0] we, input logic lb, input logic alu,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] mrd);
    bit illegal, store, load, word, mis, access, timeout;
    logic [1:0]  exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int exp_nreq, exp_lat, cyc, nreq, guard;
    bit done;

    illegal   = (we == 2'b11);
    store     = (we == 2'b01) || (we == 2'b10);
    load      = (we == 2'b00) && alu;
    word      = (we == 2'b01) || (load && !lb);
    mis       = !illegal && word && (a[1:0] != 2'b00);
    access    = (store || load) && !mis;
    timeout   = access && (ack_at > WAIT_MAX);
    exp_err   = illegal ? 2'd2 : mis ? 2'd1 : timeout ? 2'd3 : 2'd0;
    exp_nreq  = access ? ((ack_at < WAIT_MAX) ? ack_at : WAIT_MAX) : 0;
    exp_lat   = exp_nreq + 1;
    exp_be    = (we == 2'b10) ? 4'(1 << a[1:0]) : 4'hF;
    exp_wd    = (we == 2'b10) ? {4{wd[7:0]}} : wd;

    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    expect_eq("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    we_mem = we; l_byte = lb; alu_reg = alu; addr = a; wdata = wd;
    mem_ack = 1'b0;

    cyc = 0; nreq = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        nreq++;
        expect_eq("mem_addr", mem_addr, {a[31:2], 2'b00});
        expect_eq("mem_we", 32'(mem_we), 32'(store));
        expect_eq("mem_be", 32'(mem_be), 32'(exp_be));
        if (store) expect_eq("mem_wdata", mem_wdata, exp_wd);
        mem_ack   = (nreq == ack_at);
        mem_rdata = mem_ack ? mrd : $urandom;
      end else begin
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
      end
      if (resp_valid) begin
        done = 1;
        if (load && access && !timeout) begin
          ref_rdata = lb ? ((mrd >> (8 * a[1:0])) & 32'hFF) : mrd;
        end
        expect_eq("latency", cyc, exp_lat);
        expect_eq("err_code", 32'(err_code), 32'(exp_err));
        expect_eq("resp_err", 32'(resp_err), 32'(exp_err != 2'd0));
        expect_eq("rdata", rdata, ref_rdata);
        expect_eq("ready_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
      end else begin
        expect_eq("err_quiet", 32'({resp_err, err_code}), 32'd0);
        req_valid = 1'($urandom);
        scramble_inputs();
      end
    end
    if (!done) expect_eq("resp_seen", 32'd0, 32'd1);
    expect_eq("req_cycles", nreq, exp_nreq);
    @(negedge clk);
    mem_ack = 1'b0;
    expect_eq("ready_after", 32'(req_ready), 32'd1);
    expect_eq("rdata_hold", rdata, ref_rdata);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    we_mem = 2'b00; l_byte = 1'b0; alu_reg = 1'b0; addr = '0; wdata = 32'd0;
    #2;
    expect_eq("rst_ready", 32'(req_ready), 32'd1);
    expect_eq("rst_outs", 32'({resp_valid, resp_err, err_code, mem_req, mem_we, mem_be}), 32'd0);
    expect_eq("rst_rdata", rdata, 32'd0);
    expect_eq("rst_maddr", mem_addr | mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_txn(2'b01, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    run_txn(2'b10, 1'b0, 1'b0, 32'h103, 32'h000000A5, 2, 32'h0);
    run_txn(2'b00, 1'b1, 1'b1, 32'h202, 32'h0, 4, 32'h80C31122);
    run_txn(2'b00, 1'b0, 1'b1, 32'h206, 32'h0, 1, 32'h12345678);
    run_txn(2'b11, 1'b0, 1'b1, 32'h200, 32'h0, 1, 32'h0);
    run_txn(2'b00, 1'b0, 1'b0, 32'h300, 32'h0, 1, 32'h0);
    run_txn(2'b00, 1'b0, 1'b1, 32'h400, 32'h0, 100, 32'hCAFEF00D);
    run_txn(2'b00, 1'b0, 1'b1, 32'h404, 32'h0, WAIT_MAX, 32'hCAFEF00D);
    run_txn(2'b01, 1'b0, 1'b1, 32'h502, 32'h11111111, 1, 32'h0);
    run_txn(2'b10, 1'b1, 1'b1, 32'h501, 32'h22222233, 3, 32'h0);

    // Reset in the middle of a request
    @(negedge clk);
    req_valid = 1'b1; we_mem = 2'b00; alu_reg = 1'b1; l_byte = 1'b0; addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    expect_eq("pre_rst_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    expect_eq("mid_rst_req", 32'(mem_req), 32'd0);
    expect_eq("mid_rst_resp", 32'(resp_valid), 32'd0);
    expect_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    ref_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 2, 32'h0BADF00D);

    // Randomized instructions
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  r_we;
      logic [31:0] r_addr;
      r_we   = 2'($urandom_range(0, 3));
      r_addr = {20'd0, 12'($urandom)};
      run_txn(r_we, 1'($urandom), 1'($urandom), r_addr, $urandom,
              $urandom_range(1, WAIT_MAX + 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access stage that sits directly downstream of the control unit and the ALU. It takes the decoded memory controls (WEmem, Lreg, ALUreg), the ALU-computed address and the store data, and runs one handshaked transaction per instruction on a 32-bit word memory with byte enables. It returns load data (word or zero-extended byte) or an error code.

Parameters:
ADDR_W, 32, width of the byte address and of mem_addr
WAIT_MAX, 15, maximum REQ-state cycles without mem_ack before timeout (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
req_valid  in  1  upstream request valid
req_ready  out  1  block can accept a request (high only in IDLE)
we_mem  in  2  from control unit: 00 no store, 01 store word, 10 store byte, 11 illegal
l_byte  in  1  from control unit Lreg: 1 load byte (LBU), 0 load word
alu_reg  in  1  from control unit ALUreg: 1 = load instruction
addr  in  ADDR_W  byte address from ALU
wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  completion carries an error
err_code  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout
rdata  out  32  load result
mem_req  out  1  memory request
mem_we  out  1  1 write, 0 read
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_wdata  out  32  write data
mem_ack  in  1  memory completion; read data valid in the same cycle
mem_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, all other outputs 0, wait counter 0, captured operands cleared. A reset mid-transaction drops mem_req immediately; no response is issued.
- FSM states: IDLE, REQ, RESP.
- Accept: on req_valid && req_ready at an edge, capture we_mem, l_byte, alu_reg, addr and wdata. Input changes after acceptance are ignored.
- Classification of the captured request:
  - we_mem=11: illegal. Go to RESP with err_code=10; no memory access.
  - we_mem=01 or 10: store. we_mem takes priority over alu_reg.
  - we_mem=00 and alu_reg=1: load.
  - we_mem=00 and alu_reg=0: nop. Go to RESP with no error and rdata unchanged; no memory access.
- Alignment: a word store or word load with addr[1:0]!=00 goes to RESP with err_code=01 and no memory access. Byte operations are never misaligned.
- REQ: mem_req=1; address, we, be and wdata are registered and held stable until ack.
  - Store word: mem_we=1, be=1111, mem_wdata=wdata.
  - Store byte: mem_we=1, be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - Load: mem_we=0, be=1111.
- mem_ack sampled high in REQ: go to RESP. For a load, capture rdata:
  - Word load: rdata=mem_rdata.
  - Byte load: rdata={24'b0, byte lane addr[1:0]} (zero-extended, LBU semantics).
- Timeout: the wait counter increments each REQ cycle without ack. When it reaches WAIT_MAX, mem_req drops and the FSM goes to RESP with err_code=11. If ack arrives in that same cycle, ack wins (no error).
- RESP (exactly one cycle): resp_valid=1; resp_err=(err_code!=00). Next state IDLE, counter cleared.
- err_code and resp_err are valid only with resp_valid; they are 0 otherwise.
- rdata holds its value until the next successful load. Errors and stores never alter rdata.
- mem_ack outside REQ is ignored. req_valid outside IDLE is not accepted (req_ready=0).
- Latency:
  - Accept at edge N; mem_req high in cycle N+1.
  - Ack in cycle N+k gives resp_valid in cycle N+k+1.
  - Error or nop gives resp_valid in cycle N+1.
  - req_ready returns high the cycle after RESP.

Test Plan:
- Word store: addr=0x100, wdata=0xDEADBEEF, we_mem=01, ack one cycle after mem_req -> mem_addr=0x100, be=1111, mem_we=1, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, err_code=00.
- Byte store: addr=0x103, wdata=0x000000A5, we_mem=10 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- Byte load: addr=0x202, we_mem=00, alu_reg=1, l_byte=1, mem_rdata=0x80C3_1122 on ack after 3 wait cycles -> rdata=0x000000C3, resp_valid 4 cycles after mem_req rises.
- Errors: word load at addr=0x206 -> resp_valid next cycle, err_code=01, mem_req never asserted, rdata unchanged. we_mem=11 -> err_code=10.
- Timeout: WAIT_MAX=15, ack withheld -> mem_req high 15 cycles then low; resp_err=1, err_code=11. Repeat with ack in the 15th cycle -> err_code=00.
- Reset mid-REQ: rst_n low while mem_req=1 -> mem_req and resp_valid 0 immediately, req_ready=1; a new word load at 0x0 after release completes normally.
